// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with iterative unsigned shift-add MUL; optional zero/carry/overflow flags under ALU_MC_FLAGS_EN.
// Latency: 1 edge from accept for single-cycle ops, WIDTH+1 edges for MUL.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so at most one op every 2 cycles.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Result_hi
`ifdef ALU_MC_FLAGS_EN
  ,
  output logic             zero,
  output logic             carry,
  output logic             overflow
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_NOR = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL_RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             mul_last;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] mul_hi, mul_lo, mul_lo_nxt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] add_res, sub_res, alu_res;

`ifdef ALU_MC_FLAGS_EN
  logic [WIDTH:0] add_ext, sub_ext;
  logic           add_v, sub_v;

  assign add_ext = {1'b0, A} + {1'b0, B};
  assign sub_ext = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
  assign add_res = add_ext[WIDTH-1:0];
  assign sub_res = sub_ext[WIDTH-1:0];
  assign add_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_res[WIDTH-1] != A[WIDTH-1]);
  assign sub_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_res[WIDTH-1] != A[WIDTH-1]);
`else
  assign add_res = A + B;
  assign sub_res = A - B;
`endif

  always_comb begin
    alu_res = '0;
    case (ALUop)
      OP_ADD:  alu_res = add_res;
      OP_SUB:  alu_res = sub_res;
      OP_XOR:  alu_res = A ^ B;
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_NOR:  alu_res = ~(A | B);
      default: alu_res = '0;
    endcase
  end

  // One multiplier bit per cycle: add A into the high half when the LSB is set, then shift right.
  assign mul_sum    = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  assign mul_lo_nxt = {mul_sum[0], mul_lo[WIDTH-1:1]};
  assign mul_last   = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = (ALUop == OP_MUL) ? MUL_RUN : DONE;
        end
      end
      MUL_RUN: begin
        if (mul_last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      a_q       <= '0;
      mul_hi    <= '0;
      mul_lo    <= '0;
      Result    <= '0;
      Result_hi <= '0;
    end else if (accept) begin
      cnt    <= '0;
      a_q    <= A;
      mul_hi <= '0;
      mul_lo <= B;
      if (ALUop != OP_MUL) begin
        Result    <= alu_res;
        Result_hi <= '0;
      end
    end else if (state == MUL_RUN) begin
      mul_hi <= mul_sum[WIDTH:1];
      mul_lo <= mul_lo_nxt;
      cnt    <= mul_last ? '0 : cnt + CNT_W'(1);
      if (mul_last) begin
        Result    <= mul_lo_nxt;
        Result_hi <= mul_sum[WIDTH:1];
      end
    end
  end

`ifdef ALU_MC_FLAGS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept && (ALUop != OP_MUL)) begin
      zero     <= (alu_res == '0);
      carry    <= (ALUop == OP_ADD) ? add_ext[WIDTH] : (ALUop == OP_SUB) ? sub_ext[WIDTH] : 1'b0;
      overflow <= (ALUop == OP_ADD) ? add_v : (ALUop == OP_SUB) ? sub_v : 1'b0;
    end else if ((state == MUL_RUN) && mul_last) begin
      zero     <= (mul_lo_nxt == '0);
      carry    <= 1'b0;
      overflow <= 1'b0;
    end
  end
`endif

endmodule
